// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the Uart8 transmit arbiter.
package uart_tx_arb_pkg;

    localparam int BYTE_W          = 8;
    localparam int TIMEOUT_DEFAULT = 65536;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module uart_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   idx,
    output logic               found
);

    int j;

    // Scan from the farthest offset down so the nearest valid index wins last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (req_valid[j[PTR_W-1:0]]) begin
                idx   = j[PTR_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one Uart8 transmitter, one byte per grant.
// Optional per-frame watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        reqValid,
    input  logic [BYTE_W*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]        reqAck,
    output logic [NUM_REQ-1:0]        reqDone,
    output logic                      busy,
    output logic                      err,
    output logic                      txEn,
    output logic                      txStart,
    output logic [BYTE_W-1:0]         txIn,
    input  logic                      txBusy,
    input  logic                      txDone
);

    localparam int PTR_W = ptr_w(NUM_REQ);

    logic [1:0]         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [BYTE_W-1:0]  tx_in_q, tx_in_d;
    logic               tx_start_q, tx_start_d;
    logic               tx_en_q, tx_en_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [NUM_REQ-1:0] done_q, done_d;

    logic [PTR_W-1:0]   pick_idx;
    logic               pick_found;
    logic [BYTE_W-1:0]  pick_data;
    logic [PTR_W-1:0]   next_ptr;
    logic               timeout;

    uart_rr_pick #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req_valid (reqValid),
        .ptr       (ptr_q),
        .idx       (pick_idx),
        .found     (pick_found)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick_idx == PTR_W'(i)) pick_data = reqData[i*BYTE_W +: BYTE_W];
    end

    assign next_ptr = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        tx_in_d    = tx_in_q;
        tx_start_d = tx_start_q;
        tx_en_d    = en;
        ack_d      = '0;
        done_d     = '0;
        case (state_q)
            IDLE: begin
                if (en && tx_en_q && pick_found && !txBusy) begin
                    state_d           = START;
                    owner_d           = pick_idx;
                    tx_in_d           = pick_data;
                    ack_d[pick_idx]   = 1'b1;
                    tx_start_d        = 1'b1;
                end
            end
            START, WAIT_DONE: begin
                // Abort drops the byte without advancing ptr; a done seen in START counts as completion.
                if (!en) begin
                    state_d    = IDLE;
                    tx_start_d = 1'b0;
                end else if (txDone) begin
                    done_d[owner_q] = 1'b1;
                    ptr_d           = next_ptr;
                    state_d         = IDLE;
                    tx_start_d      = 1'b0;
                end else if (timeout) begin
                    ptr_d      = next_ptr;
                    state_d    = IDLE;
                    tx_start_d = 1'b0;
                end else if (state_q == START && txBusy) begin
                    tx_start_d = 1'b0;
                    state_d    = WAIT_DONE;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            tx_in_q    <= '0;
            tx_start_q <= 1'b0;
            tx_en_q    <= 1'b0;
            ack_q      <= '0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            tx_in_q    <= tx_in_d;
            tx_start_q <= tx_start_d;
            tx_en_q    <= tx_en_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter sits at zero in IDLE, so it is already cleared on the grant edge.
    always_comb begin
        cnt_d = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
        err_d = (state_q != IDLE) && en && !txDone && timeout;
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYCLES only matters with the watchdog compiled in.
    assign err     = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

    assign reqAck  = ack_q;
    assign reqDone = done_q;
    assign busy    = (state_q != IDLE);
    assign txEn    = tx_en_q;
    assign txStart = tx_start_q;
    assign txIn    = tx_in_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a behavioural Uart8 loopback.
// Watchdog case runs only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 100;

    typedef struct packed {
        logic [1:0] idx;
        logic [7:0] data;
    } item_t;

    logic           clk = 1'b0;
    logic           rstN;
    logic           en;
    logic [N-1:0]   reqValid;
    logic [8*N-1:0] reqData;
    logic [N-1:0]   reqAck;
    logic [N-1:0]   reqDone;
    logic           busy;
    logic           err;
    logic           txEn;
    logic           txStart;
    logic [7:0]     txIn;
    logic           txBusy;
    logic           txDone;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .en       (en),
        .reqValid (reqValid),
        .reqData  (reqData),
        .reqAck   (reqAck),
        .reqDone  (reqDone),
        .busy     (busy),
        .err      (err),
        .txEn     (txEn),
        .txStart  (txStart),
        .txIn     (txIn),
        .txBusy   (txBusy),
        .txDone   (txDone)
    );

    int         checks = 0;
    int         passes = 0;
    item_t      ack_q[$];
    item_t      done_q[$];
    logic [7:0] req_bytes[N][$];
    bit         uart_auto = 1'b1;
    bit         allow_err = 1'b0;
    logic [7:0] rx_last = '0;
    logic [7:0] cap = '0;
    int         phase = 0;
    int         wt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int idx_of(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic load(input int i, input logic [7:0] b, input bit exp_done);
        item_t it;
        it.idx  = 2'(i);
        it.data = b;
        req_bytes[i].push_back(b);
        if (!reqValid[i]) begin
            reqData[i*8 +: 8] = b;
            reqValid[i]       = 1'b1;
        end
        ack_q.push_back(it);
        if (exp_done) done_q.push_back(it);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((ack_q.size() + done_q.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({"drain_", tag}, ack_q.size() + done_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_ack(input int i, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!reqAck[i] && n < 50);
        chk({"ack_seen_", tag}, reqAck[i], 1);
    endtask

    // Uart8 stand-in: busy two cycles after txStart, done four cycles later.
    initial begin
        txBusy = 1'b0;
        txDone = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstN || !txEn) begin
                txBusy = 1'b0;
                txDone = 1'b0;
                phase  = 0;
            end else begin
                case (phase)
                    0: if (txStart && uart_auto) begin
                        cap   = txIn;
                        wt    = 2;
                        phase = 1;
                    end
                    1: begin
                        wt = wt - 1;
                        if (wt == 0) begin
                            txBusy = 1'b1;
                            wt     = 4;
                            phase  = 2;
                        end
                    end
                    2: begin
                        wt = wt - 1;
                        if (wt == 0) begin
                            txBusy  = 1'b0;
                            txDone  = 1'b1;
                            rx_last = cap;
                            phase   = 3;
                        end
                    end
                    default: begin
                        txDone = 1'b0;
                        phase  = 0;
                    end
                endcase
            end
        end
    end

    // Scoreboard monitor and requester behaviour.
    initial begin
        forever begin
            @(negedge clk);
            if (rstN) begin
                if (|reqAck) begin : mon_ack
                    item_t e;
                    int    i;
                    chk("ack_onehot", 32'($onehot(reqAck)), 1);
                    chk("ack_done_excl", 32'(|reqDone), 0);
                    if (ack_q.size() == 0) chk("ack_unexpected", 32'(reqAck), 0);
                    else begin
                        e = ack_q.pop_front();
                        chk("ack_idx", idx_of(reqAck), 32'(e.idx));
                        chk("ack_txIn", 32'(txIn), 32'(e.data));
                    end
                    i = idx_of(reqAck);
                    if (i >= 0 && req_bytes[i].size() > 0) begin
                        void'(req_bytes[i].pop_front());
                        if (req_bytes[i].size() > 0) reqData[i*8 +: 8] = req_bytes[i][0];
                        else reqValid[i] = 1'b0;
                    end
                end
                if (|reqDone) begin : mon_done
                    item_t e;
                    chk("done_onehot", 32'($onehot(reqDone)), 1);
                    if (done_q.size() == 0) chk("done_unexpected", 32'(reqDone), 0);
                    else begin
                        e = done_q.pop_front();
                        chk("done_idx", idx_of(reqDone), 32'(e.idx));
                        chk("done_rx", 32'(rx_last), 32'(e.data));
                    end
                end
                if (err && !allow_err) chk("err_unexpected", 32'(err), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        rstN     = 1'b0;
        en       = 1'b1;
        reqValid = '0;
        reqData  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_txEn",    32'(txEn), 0);
        chk("rst_txStart", 32'(txStart), 0);
        chk("rst_txIn",    32'(txIn), 0);
        chk("rst_reqAck",  32'(reqAck), 0);
        chk("rst_reqDone", 32'(reqDone), 0);
        chk("rst_err",     32'(err), 0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        chk("txEn_follows_en", 32'(txEn), 1);

        // Single requester, with txStart held until busy
        load(0, 8'h45, 1'b1);
        wait_ack(0, "t1");
        chk("t1_txStart", 32'(txStart), 1);
        chk("t1_busy", 32'(busy), 1);
        @(negedge clk);
        chk("t1_start_held", 32'(txStart), 1);
        n = 0;
        while (!txBusy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("t1_start_drop", 32'(txStart), 0);
        wait_drain("t1");

        // Reset mid-frame
        load(1, 8'h11, 1'b0);
        wait_ack(1, "rst");
        repeat (2) @(negedge clk);
        rstN = 1'b0;
        #1;
        chk("mrst_busy",    32'(busy), 0);
        chk("mrst_txStart", 32'(txStart), 0);
        chk("mrst_txIn",    32'(txIn), 0);
        chk("mrst_txEn",    32'(txEn), 0);
        chk("mrst_ack",     32'(reqAck), 0);
        chk("mrst_err",     32'(err), 0);
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_idle", 32'(busy), 0);
        wait_drain("mrst");

        // All four valid from ptr=0: grant order 0,1,2,3,0
        load(0, 8'hA0, 1'b1);
        load(1, 8'hA1, 1'b1);
        load(2, 8'hA2, 1'b1);
        load(3, 8'hA3, 1'b1);
        load(0, 8'hA4, 1'b1);
        wait_drain("rr4");

        // ptr=1 now; a lone grant to 2 moves ptr to 3, then 3 and 0 wrap
        load(2, 8'h22, 1'b1);
        wait_drain("pre_wrap");
        load(3, 8'h33, 1'b1);
        load(0, 8'h30, 1'b1);
        wait_drain("wrap");

        // en dropped in WAIT_DONE: abort, no reqDone, ptr stays at 1
        load(1, 8'h55, 1'b0);
        wait_ack(1, "endrop");
        n = 0;
        while (!txBusy && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("endrop_txEn", 32'(txEn), 0);
        chk("endrop_busy", 32'(busy), 0);
        chk("endrop_txStart", 32'(txStart), 0);
        repeat (10) @(negedge clk);
        en = 1'b1;
        repeat (2) @(negedge clk);
        load(1, 8'h57, 1'b1);
        load(2, 8'h66, 1'b1);
        wait_drain("ptr_kept");

`ifdef UART_TX_ARB_TIMEOUT_EN
        // ptr=3; Uart never goes busy, so requester 0 times out and 1 follows
        allow_err = 1'b1;
        uart_auto = 1'b0;
        load(0, 8'h70, 1'b0);
        load(1, 8'h71, 1'b1);
        wait_ack(0, "to");
        n = 0;
        while (!err && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("to_err_seen", 32'(err), 1);
        chk("to_err_cycle", n, TO);
        uart_auto = 1'b1;
        @(negedge clk);
        allow_err = 1'b0;
        chk("to_err_pulse", 32'(err), 0);
        wait_drain("to");
`else
        chk("err_tied_low", 32'(err), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
